// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - sprite geometry, attribute record and 4x16x16 shape masks
package sprite_pkg;

    localparam int SPRITE_W   = 16;
    localparam int SPRITE_H   = 16;
    localparam int NUM_SHAPES = 4;

    typedef struct packed {
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic [1:0]         shape;
        logic [23:0]        color;
        logic               vis;
    } sprite_attr_t;

    // [shape][row dy][column dx]; bit dx of each row word is column dx
    localparam logic [0:NUM_SHAPES-1][0:SPRITE_H-1][SPRITE_W-1:0] SPRITE_MASK = '{
        '{16'h0180, 16'h03C0, 16'h03C0, 16'h07E0, 16'h07E0, 16'h0FF0, 16'h0FF0, 16'h1FF8,
          16'h3FFC, 16'h7FFE, 16'hFFFF, 16'hFFFF, 16'hE7E7, 16'hC3C3, 16'h8181, 16'h0000},
        '{16'h0FF0, 16'h1FF8, 16'h3FFC, 16'h7FFE, 16'hE667, 16'hE667, 16'hFFFF, 16'hFFFF,
          16'hFFFF, 16'h7FFE, 16'h3FFC, 16'h1998, 16'h300C, 16'h6006, 16'hC003, 16'h0000},
        '{16'h8001, 16'h4002, 16'h2004, 16'h1FF8, 16'h3FFC, 16'h6666, 16'hFFFF, 16'hFFFF,
          16'hBFFD, 16'hA005, 16'hA005, 16'h1818, 16'h1818, 16'h0000, 16'h0000, 16'h0000},
        '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
          16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}
    };

endpackage

// File: rtl/sprite_shape_rom.sv
// rtl/sprite_shape_rom.sv - combinational (shape, dy, dx) -> mask bit lookup
module sprite_shape_rom
    import sprite_pkg::*;
(
    input  logic [1:0] shape,
    input  logic [3:0] dy,
    input  logic [3:0] dx,
    output logic       pix_on
);

    assign pix_on = SPRITE_MASK[shape][dy][dx];

endmodule

// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - sprite compositor, shadow/live banks, 2-stage pipeline; SPRITE_COLLISION_EN adds collision flags
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int          NUM_SPRITES = 8,
    parameter logic [23:0] BG_COLOR    = 24'h000000,
    localparam int         IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                     pixel_clk,
    input  logic                     resetn,
    input  logic signed [11:0]       hpos,
    input  logic signed [11:0]       vpos,
    input  logic                     active,
    input  logic                     fsync,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic signed [11:0]       wr_x,
    input  logic signed [11:0]       wr_y,
    input  logic [1:0]               wr_shape,
    input  logic [23:0]              wr_color,
    input  logic                     wr_vis,
    output logic [7:0]               pixel [0:2],
    output logic                     pixel_valid
`ifdef SPRITE_COLLISION_EN
    ,
    output logic [NUM_SPRITES-1:0]   collision
`endif
);

    sprite_attr_t shadow [NUM_SPRITES];
    sprite_attr_t live   [NUM_SPRITES];
    logic         wr_ok;

    assign wr_ok = wr_en && (int'(wr_idx) < NUM_SPRITES);

    // Nonblocking copy means a same-cycle write lands only in the shadow bank
    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i] <= '0;
                live[i]   <= '0;
            end
        end else begin
            if (fsync) live <= shadow;
            if (wr_ok) shadow[wr_idx] <= '{x: wr_x, y: wr_y, shape: wr_shape,
                                           color: wr_color, vis: wr_vis};
        end
    end

    logic [NUM_SPRITES-1:0] hit;
    logic [23:0]            slot_color [NUM_SPRITES];
    logic                   s1_active;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
        logic [12:0] dx;
        logic [12:0] dy;
        logic        inbox;
        logic        inbox_q;
        logic        mask_bit;
        logic [3:0]  dx_q;
        logic [3:0]  dy_q;
        logic [1:0]  shape_q;
        logic [23:0] color_q;

        // 13-bit difference of sign-extended 12-bit operands cannot overflow
        assign dx    = {hpos[11], hpos} - {live[g].x[11], live[g].x};
        assign dy    = {vpos[11], vpos} - {live[g].y[11], live[g].y};
        assign inbox = live[g].vis & active & (dx[12:4] == '0) & (dy[12:4] == '0);

        // Shape and colour travel with the pixel so a bank copy cannot split it
        always_ff @(posedge pixel_clk or negedge resetn) begin
            if (!resetn) begin
                inbox_q <= 1'b0;
                dx_q    <= '0;
                dy_q    <= '0;
                shape_q <= '0;
                color_q <= '0;
            end else begin
                inbox_q <= inbox;
                dx_q    <= dx[3:0];
                dy_q    <= dy[3:0];
                shape_q <= live[g].shape;
                color_q <= live[g].color;
            end
        end

        sprite_shape_rom u_rom (
            .shape  (shape_q),
            .dy     (dy_q),
            .dx     (dx_q),
            .pix_on (mask_bit)
        );

        assign hit[g]        = inbox_q & mask_bit;
        assign slot_color[g] = color_q;
    end

    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) s1_active <= 1'b0;
        else         s1_active <= active;
    end

    logic [23:0] win_color;

    always_comb begin
        win_color = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) win_color = slot_color[i];
        end
    end

    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            pixel[0]    <= '0;
            pixel[1]    <= '0;
            pixel[2]    <= '0;
            pixel_valid <= 1'b0;
        end else begin
            pixel[0]    <= s1_active ? win_color[7:0]   : 8'h00;
            pixel[1]    <= s1_active ? win_color[15:8]  : 8'h00;
            pixel[2]    <= s1_active ? win_color[23:16] : 8'h00;
            pixel_valid <= s1_active;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] sticky;
    logic                   multi_hit;

    assign multi_hit = (hit & (hit - NUM_SPRITES'(1))) != '0;

    // Hits seen in the fsync cycle itself count toward the next frame
    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            sticky    <= '0;
            collision <= '0;
        end else if (fsync) begin
            collision <= sticky;
            sticky    <= multi_hit ? hit : '0;
        end else if (multi_hit) begin
            sticky    <= sticky | hit;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// tb/tb_sprite_engine.sv - scoreboard bench for sprite_engine with a positional reference model
module tb_sprite_engine;
    import sprite_pkg::*;

    localparam int          NS = 8;
    localparam logic [23:0] BG = 24'h102030;

    logic               pixel_clk = 1'b0;
    logic               resetn = 1'b0;
    logic signed [11:0] hpos = '0, vpos = '0, wr_x = '0, wr_y = '0;
    logic               active = 1'b0, fsync = 1'b0, wr_en = 1'b0, wr_vis = 1'b0;
    logic [2:0]         wr_idx = '0;
    logic [1:0]         wr_shape = '0;
    logic [23:0]        wr_color = '0;
    logic [7:0]         pixel [0:2];
    logic               pixel_valid;
`ifdef SPRITE_COLLISION_EN
    logic [NS-1:0]      collision;
`endif

    sprite_engine #(.NUM_SPRITES(NS), .BG_COLOR(BG)) dut (
        .pixel_clk   (pixel_clk),
        .resetn      (resetn),
        .hpos        (hpos),
        .vpos        (vpos),
        .active      (active),
        .fsync       (fsync),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_shape    (wr_shape),
        .wr_color    (wr_color),
        .wr_vis      (wr_vis),
        .pixel       (pixel),
`ifdef SPRITE_COLLISION_EN
        .collision   (collision),
`endif
        .pixel_valid (pixel_valid)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct { int x; int y; int shape; logic [23:0] color; bit vis; } m_t;
    typedef struct { int due; logic valid; logic [23:0] rgb; } exp_t;

    m_t   m_shadow [NS];
    m_t   m_live   [NS];
    exp_t exp_q [$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    bit          p_we = 0, p_vis = 0;
    int          p_idx = 0, p_x = 0, p_y = 0, p_shape = 0;
    logic [23:0] p_col = '0;
    logic [23:0] got;

    assign got = {pixel[2], pixel[1], pixel[0]};

    always @(posedge pixel_clk) cyc <= cyc + 1;

    // Lowest-numbered visible slot whose mask covers (h, v) supplies the colour
    function automatic logic [23:0] model_rgb(int h, int v);
        for (int i = 0; i < NS; i++) begin
            int dx = h - m_live[i].x;
            int dy = v - m_live[i].y;
            if (m_live[i].vis && dx >= 0 && dx < SPRITE_W && dy >= 0 && dy < SPRITE_H) begin
                if (m_live[i].shape == 3 || SPRITE_MASK[m_live[i].shape][dy][dx])
                    return m_live[i].color;
            end
        end
        return BG;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_shadow[i] = '{x: 0, y: 0, shape: 0, color: 24'h0, vis: 0};
            m_live[i]   = '{x: 0, y: 0, shape: 0, color: 24'h0, vis: 0};
        end
    endtask

    task automatic wr(input int idx, input int x, input int y, input int shp,
                      input logic [23:0] col, input bit vis);
        p_we = 1; p_idx = idx; p_x = x; p_y = y; p_shape = shp; p_col = col; p_vis = vis;
    endtask

    task automatic step(input int h, input int v, input bit act, input bit fs);
        exp_t e;
        @(posedge pixel_clk); #1;
        hpos = 12'(h); vpos = 12'(v); active = act; fsync = fs;
        wr_en = p_we; wr_idx = 3'(p_idx); wr_x = 12'(p_x); wr_y = 12'(p_y);
        wr_shape = 2'(p_shape); wr_color = p_col; wr_vis = p_vis;
        e.due = cyc + 2; e.valid = act; e.rgb = act ? model_rgb(h, v) : 24'h0;
        exp_q.push_back(e);
        if (fs) m_live = m_shadow;
        if (p_we) m_shadow[p_idx] = '{x: p_x, y: p_y, shape: p_shape, color: p_col, vis: p_vis};
        p_we = 0;
    endtask

    task automatic scan(input int x0, input int y0, input int w, input int hgt);
        for (int v = y0; v < y0 + hgt; v++)
            for (int h = x0; h < x0 + w; h++)
                step(h, v, 1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
        end
    endtask

    always @(negedge pixel_clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (e.due != cyc || pixel_valid !== e.valid || got !== e.rgb) begin
                n_fail++;
                $display("FAIL pixel due=%0d at=%0d: got valid=%b rgb=%h expected valid=%b rgb=%h",
                         e.due, cyc, pixel_valid, got, e.valid, e.rgb);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_clear();
        repeat (3) @(posedge pixel_clk);
        #1;
        check("reset_pixel", 32'(got), 32'h0);
        check("reset_valid", 32'(pixel_valid), 32'h0);
        resetn = 1'b1;
        idle(2);

        // Basic placement, solid square at (100,50)
        wr(0, 100, 50, 3, 24'hFF0000, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        scan(99, 49, 18, 18);

        // Write before fsync is deferred; write during fsync is deferred one frame
        wr(0, 200, 80, 3, 24'h00FF00, 1);
        step(0, 0, 0, 0);
        scan(99, 50, 3, 1);
        scan(199, 80, 3, 1);
        step(0, 0, 0, 1);
        scan(99, 50, 3, 1);
        scan(199, 79, 18, 3);
        wr(0, 300, 100, 2, 24'h0000FF, 1);
        step(0, 0, 0, 1);
        scan(199, 80, 3, 1);
        scan(300, 100, 16, 16);
        step(0, 0, 0, 1);
        scan(199, 80, 3, 1);
        scan(300, 100, 16, 16);

        // Overlapping slots 1 and 3, lower index wins
        wr(1, 400, 200, 3, 24'h112233, 1);
        step(0, 0, 0, 0);
        wr(3, 404, 204, 3, 24'h445566, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        scan(398, 198, 24, 24);
        idle(3);
        step(0, 0, 0, 1);
        idle(1);
`ifdef SPRITE_COLLISION_EN
        check("collision", 32'(collision), 32'h0A);
`endif

        // Left-clipped sprite and inactive cycles
        wr(2, -8, 600, 1, 24'hABCDEF, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        scan(-10, 600, 20, 16);
        for (int h = -4; h < 10; h++) step(h, 604, 0, 0);

        // Randomised traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(7) == 0)
                wr($urandom_range(NS - 1), int'($urandom_range(90)) - 20, int'($urandom_range(90)) - 20,
                   $urandom_range(3), 24'($urandom), bit'($urandom_range(3) != 0));
            step(int'($urandom_range(100)) - 20, int'($urandom_range(100)) - 20,
                 $urandom_range(7) != 0, $urandom_range(39) == 0);
        end

        // Asynchronous reset mid-frame with a visible sprite under the beam
        wr(0, 40, 40, 3, 24'hFFFFFF, 1);
        step(0, 0, 0, 1);
        scan(40, 40, 4, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_pixel", 32'(got), 32'h0);
        check("async_reset_valid", 32'(pixel_valid), 32'h0);
        exp_q.delete();
        model_clear();
        repeat (2) @(posedge pixel_clk);
        #1;
        resetn = 1'b1;
        step(0, 0, 0, 1);
        scan(38, 38, 20, 4);
        scan(98, 48, 4, 4);

        idle(1);
        repeat (4) @(posedge pixel_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
# sprite_engine

Per-pixel sprite compositor that produces the RGB pixel data consumed by the HDMI transmit stage. It takes the transmit stage's `hpos`/`vpos`/`active`/`fsync` timing, evaluates up to `NUM_SPRITES` 16x16 one-bit-mask sprites against the current position, and outputs the colour of the highest-priority opaque sprite, or the background colour. Game logic updates sprite attributes through a write port into a shadow bank, which is copied to the live bank at each `fsync` so that frames never tear.

## Interface
Parameters:
- `NUM_SPRITES`, default 8: number of sprite slots (1–16).
- `BG_COLOR`, default 24'h000000: background RGB, packed {R,G,B}.

Ports:
- `pixel_clk` (in, 1): pixel clock; the only clock.
- `resetn` (in, 1): asynchronous, active-low reset.
- `hpos` (in, 12, signed): horizontal position from the transmit stage.
- `vpos` (in, 12, signed): vertical position from the transmit stage.
- `active` (in, 1): active-video qualifier.
- `fsync` (in, 1): one-cycle start-of-frame pulse.
- `wr_en` (in, 1): sprite attribute write strobe.
- `wr_idx` (in, $clog2(NUM_SPRITES)): slot to write.
- `wr_x` (in, 12, signed): sprite left edge.
- `wr_y` (in, 12, signed): sprite top edge.
- `wr_shape` (in, 2): shape ROM index.
- `wr_color` (in, 24): sprite RGB, packed {R,G,B}.
- `wr_vis` (in, 1): sprite visible.
- `pixel` (out, [7:0] x [0:2]): output colour; 0=Blue, 1=Green, 2=Red.
- `pixel_valid` (out, 1): `active` delayed to align with `pixel`.
- `collision` (out, NUM_SPRITES): per-slot collision flags; present only with the macro defined.

## Operation
- Shadow bank:
  - Written on any cycle `wr_en`=1; `wr_idx` ≥ NUM_SPRITES is ignored.
  - All fields of the addressed slot are written in the same cycle.
- Live bank:
  - Copied in full from the shadow bank on the cycle `fsync`=1.
  - Same-cycle `wr_en` and `fsync`: the live bank receives the pre-write shadow contents, and the write lands in the shadow only. The write takes effect from the next frame.
- Stage 1, per slot:
  - Compute `dx = hpos - x` and `dy = vpos - y`, 13-bit signed, with no overflow.
  - `inbox = vis & active & 0≤dx<16 & 0≤dy<16`.
  - Negative and off-screen coordinates are legal; the sprite is clipped.
  - Register `inbox`, `dx[3:0]`, `dy[3:0]`, `active`.
- Stage 2, per slot:
  - `hit = inbox & mask[shape][dy][dx]`.
  - Priority: the lowest index with `hit`=1 wins, and its colour drives `pixel`.
  - No hit: `pixel` = BG_COLOR.
  - Stage-1 `active` low: `pixel` = 0.
- No back-pressure, no stalls; the block accepts one position per cycle continuously.

## Timing
- Latency: exactly 2 cycles from `hpos`/`vpos`/`active` to `pixel`/`pixel_valid`. Integration delays sync and active to the encoder by 2 cycles.
- Reset values:
  - `pixel` = 0, `pixel_valid` = 0, `collision` = 0.
  - All shadow and live slots have `vis` = 0; the other fields are 0.
- Reset mid-frame:
  - Pipeline is flushed immediately (asynchronous).
  - After release, output is BG/0 until sprites are rewritten and an `fsync` occurs.
- `fsync` with `active`=1 in the same cycle: the bank copy takes effect for pixels entering stage 1 on the next cycle.

## Configuration
- `SPRITE_COLLISION_EN` defined:
  - Any stage-2 cycle with two or more `hit` bits sets the sticky internal flag of every hitting slot.
  - On `fsync`, the sticky flags are transferred to `collision` and then cleared.
  - `collision` holds that value for the whole following frame.
- Not defined:
  - No collision port and no collision logic.
  - Compositing behaviour is identical to the defined case.

## Structure
- Package `sprite_pkg`:
  - `SPRITE_W`=16, `SPRITE_H`=16, `NUM_SHAPES`=4.
  - `sprite_attr_t` struct {x, y, shape, color, vis}.
  - 4x16x16 mask constant: 0=player ship, 1=enemy A, 2=enemy B, 3=solid square.
- Sub-module `sprite_shape_rom`:
  - Combinational lookup of (shape, dy, dx) → bit.
  - One instance per slot, generated.

## Test plan
- Slot 0 at (100,50), shape 3, colour FF0000, `fsync`, then scan (100,50)–(115,65) → `pixel` {B,G,R}={00,00,FF} 2 cycles later. Pixel (116,50) and (99,50) → BG.
- Write before `fsync` → no change for the current frame; new position appears after the next `fsync`. Write in the `fsync` cycle → appears one frame later.
- Slots 1 and 3 overlap at the same pixel, shape 3 → slot 1 colour wins. With `SPRITE_COLLISION_EN`, after the next `fsync`, `collision` = 8'b0000_1010.
- Slot at x=-8 → only dx 8..15, at hpos 0..7, are drawn; with `active` low, `pixel`=0 and `pixel_valid`=0.
- `resetn` pulsed low mid-frame with visible sprites → `pixel`=0 asynchronously. After release and one `fsync` with no writes → BG everywhere.
